// File: rtl/tagged_value_pkg.sv
// tagged_value_pkg: value tags, payload sizes and frame states shared by serializer and deserializer
package tagged_value_pkg;
    typedef enum logic [1:0] {TYPE_EMPTY, TYPE_INT, TYPE_STRING, TYPE_REAL} value_type_e;
    typedef enum logic [1:0] {S_IDLE, S_TAG, S_LEN, S_PAYLOAD} ser_state_e;
    localparam int INT_BYTES  = 4;
    localparam int REAL_BYTES = 8;
endpackage

// File: rtl/tagged_value_serializer.sv
// tagged_value_serializer: turns one tagged value into a TAG, LEN, payload byte frame
module tagged_value_serializer
    import tagged_value_pkg::*;
#(
    parameter int MAX_STR_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_type,
    input  logic [31:0]                in_int,
    input  logic [63:0]                in_real,
    input  logic [8*MAX_STR_BYTES-1:0] in_str,
    input  logic [7:0]                 in_str_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    output logic [15:0]                frame_count,
    output logic                       len_err
);
    localparam int PB = MAX_STR_BYTES > REAL_BYTES ? MAX_STR_BYTES : REAL_BYTES;
    localparam int PW = 8 * PB;
    localparam logic [7:0] STR_CAP = 8'(MAX_STR_BYTES);

    ser_state_e  state_q, state_d;
    value_type_e type_q, type_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [PW-1:0] pay_q, pay_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        len_err_q, len_err_d;
    value_type_e in_type_e;
    logic [7:0]  str_len;
    logic [7:0]  pay_byte;

    assign in_type_e   = value_type_e'(in_type);
    assign str_len     = in_str_len > STR_CAP ? STR_CAP : in_str_len;
    assign pay_byte    = 8'(pay_q >> {cnt_q, 3'b000});
    assign in_ready    = state_q == S_IDLE;
    assign out_valid   = state_q != S_IDLE;
    assign out_last    = (state_q == S_LEN && len_q == 8'd0) ||
                         (state_q == S_PAYLOAD && cnt_q == len_q - 8'd1);
    assign out_data    = state_q == S_TAG     ? {6'b0, type_q} :
                         state_q == S_LEN     ? len_q :
                         state_q == S_PAYLOAD ? pay_byte : 8'h00;
    assign frame_count = frame_count_q;
    assign len_err     = len_err_q;

    // Frame sequencing: capture on accept, then step one byte per sink handshake
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        pay_d         = pay_q;
        frame_count_d = frame_count_q;
        len_err_d     = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d   = S_TAG;
                type_d    = in_type_e;
                cnt_d     = 8'd0;
                len_d     = in_type_e == TYPE_INT    ? 8'(INT_BYTES) :
                            in_type_e == TYPE_REAL   ? 8'(REAL_BYTES) :
                            in_type_e == TYPE_STRING ? str_len : 8'd0;
                pay_d     = in_type_e == TYPE_INT    ? PW'(in_int) :
                            in_type_e == TYPE_REAL   ? PW'(in_real) :
                            in_type_e == TYPE_STRING ? PW'(in_str) : '0;
                len_err_d = in_type_e == TYPE_STRING && in_str_len > STR_CAP;
            end
            S_TAG: if (out_ready) state_d = S_LEN;
            S_LEN: if (out_ready) state_d = len_q == 8'd0 ? S_IDLE : S_PAYLOAD;
            default: if (out_ready) begin
                state_d = out_last ? S_IDLE : S_PAYLOAD;
                cnt_d   = cnt_q + 8'd1;
            end
        endcase
        if (out_valid && out_ready && out_last) frame_count_d = frame_count_q + 16'd1;
    end

    // State and capture registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            type_q        <= TYPE_EMPTY;
            len_q         <= 8'd0;
            cnt_q         <= 8'd0;
            pay_q         <= '0;
            frame_count_q <= 16'd0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            pay_q         <= pay_d;
            frame_count_q <= frame_count_d;
            len_err_q     <= len_err_d;
        end
    end
endmodule

// File: tb/tb_tagged_value_serializer.sv
// tb_tagged_value_serializer: directed frames checked through an expected-byte scoreboard
module tb_tagged_value_serializer;
    localparam int M = 16;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_type = 2'd0;
    logic [31:0]    in_int = 32'd0;
    logic [63:0]    in_real = 64'd0;
    logic [8*M-1:0] in_str = '0;
    logic [7:0]     in_str_len = 8'd0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [7:0]     out_data;
    logic           out_last;
    logic [15:0]    frame_count;
    logic           len_err;

    tagged_value_serializer #(.MAX_STR_BYTES(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_int(in_int), .in_real(in_real), .in_str(in_str),
        .in_str_len(in_str_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_count(frame_count),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    logic [8:0] q[$];
    int checks = 0;
    int errors = 0;
    int nbytes = 0;
    int nlenerr = 0;
    bit tog = 1'b0;
    logic prev_stall = 1'b0;
    logic [8:0] prev_byte = 9'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ex(input logic [7:0] b, input logic l);
        q.push_back({l, b});
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && out_valid) chk("stall_hold", {23'd0, out_last, out_data}, {23'd0, prev_byte});
            if (len_err) nlenerr++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", {out_last, out_data});
                end else begin
                    chk("byte", {23'd0, out_last, out_data}, {23'd0, q.pop_front()});
                end
                nbytes++;
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Sink readiness: steady or alternating every cycle
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = tog ? ~out_ready : 1'b1;
    end

    task automatic send(input logic [1:0] t, input logic [31:0] i, input logic [63:0] r,
                        input logic [8*M-1:0] s, input logic [7:0] l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        in_valid = 1'b1; in_type = t; in_int = i; in_real = r; in_str = s; in_str_len = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_type = 2'($urandom); in_int = 32'hDEADBEEF;
        in_real = {2{32'hCAFEF00D}}; in_str = {M{8'hEE}}; in_str_len = 8'hFF;
    endtask

    task automatic drain;
        int n = 0;
        @(negedge clk);
        while (!(q.size() == 0 && in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending bytes expected 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8*M-1:0] s;
        int base;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_len_err", {31'd0, len_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ex(8'h01, 0); ex(8'h04, 0); ex(8'h2A, 0); ex(8'h00, 0); ex(8'h00, 0); ex(8'h00, 1);
        send(2'd1, 32'd42, 64'd0, '0, 8'd0);
        drain();
        chk("fc_int42", {16'd0, frame_count}, 32'd1);

        s = {{14{8'h5A}}, 8'h69, 8'h48};
        ex(8'h02, 0); ex(8'h02, 0); ex(8'h48, 0); ex(8'h69, 1);
        send(2'd2, 32'd0, 64'd0, s, 8'd2);
        drain();
        chk("len_err_hi", nlenerr, 32'd0);
        chk("fc_hi", {16'd0, frame_count}, 32'd2);

        ex(8'h03, 0); ex(8'h08, 0); ex(8'h6E, 0); ex(8'h86, 0); ex(8'h1B, 0);
        ex(8'hF0, 0); ex(8'hF9, 0); ex(8'h21, 0); ex(8'h09, 0); ex(8'h40, 1);
        send(2'd3, 32'd0, 64'h400921F9F01B866E, '0, 8'd0);
        drain();
        chk("fc_real", {16'd0, frame_count}, 32'd3);

        tog = 1'b1;
        ex(8'h01, 0); ex(8'h04, 0); ex(8'h9C, 0); ex(8'hFF, 0); ex(8'hFF, 0); ex(8'hFF, 1);
        send(2'd1, 32'hFFFFFF9C, 64'd0, '0, 8'd0);
        drain();
        tog = 1'b0;
        chk("fc_neg100", {16'd0, frame_count}, 32'd4);

        ex(8'h00, 0); ex(8'h00, 1);
        send(2'd0, 32'd5, 64'd5, '1, 8'd5);
        drain();
        chk("fc_empty", {16'd0, frame_count}, 32'd5);

        for (int i = 0; i < M; i++) s[8*i +: 8] = 8'h41 + 8'(i);
        ex(8'h02, 0); ex(8'h10, 0);
        for (int i = 0; i < M; i++) ex(8'h41 + 8'(i), i == M - 1);
        send(2'd2, 32'd0, 64'd0, s, 8'd20);
        drain();
        chk("len_err_pulse", nlenerr, 32'd1);
        chk("fc_long", {16'd0, frame_count}, 32'd6);

        base = nbytes;
        ex(8'h01, 0); ex(8'h04, 0); ex(8'h44, 0); ex(8'h33, 0); ex(8'h22, 0); ex(8'h11, 1);
        send(2'd1, 32'h11223344, 64'd0, '0, 8'd0);
        for (int n = 0; n < 100 && nbytes < base + 3; n++) @(posedge clk);
        chk("abort_bytes_seen", nbytes - base, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_frame_count", {16'd0, frame_count}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        ex(8'h01, 0); ex(8'h04, 0); ex(8'h07, 0); ex(8'h00, 0); ex(8'h00, 0); ex(8'h00, 1);
        send(2'd1, 32'd7, 64'd0, '0, 8'd0);
        drain();
        chk("fc_after_rst", {16'd0, frame_count}, 32'd1);
        chk("byte_total", nbytes - base, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
